// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_responder
//  Purpose  : Slave end of the CPU data bus. Word-addressed data RAM plus a
//             16-byte register block (CYCLE_CNT, SCRATCH, STATUS, ERR_ADDR).
//             Writes commit on the access edge; reads return registered data
//             one cycle later, and the bus floats (z) otherwise.
//  Ports    : CLK            - system clock, rising edge
//             RST            - synchronous reset, active-low
//             ADDR[31:0]     - byte address, ADDR[1:0] ignored
//             Data_BUS_WRITE - write data
//             CS             - access strobe
//             WR             - 1 = write, 0 = read (qualifies CS)
//             Data_BUS_READ  - registered read data, z when idle
//             ERR_IRQ        - level copy of STATUS.ERR
//  Revision : 1.0 - initial release
// ============================================================================
module data_bus_responder #(
  parameter int          RAM_AW        = 10,
  parameter logic [31:0] RAM_BASE      = 32'h0000_0000,
  parameter logic [31:0] IO_BASE       = 32'h0000_FF00,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  input  logic        CS,
  input  logic        WR,
  output logic [31:0] Data_BUS_READ,
  output logic        ERR_IRQ
);

  localparam int         RAM_DEPTH = 2 ** RAM_AW;
  localparam logic [1:0] OFF_CNT   = 2'd0;
  localparam logic [1:0] OFF_SCR   = 2'd1;
  localparam logic [1:0] OFF_STAT  = 2'd2;

  logic [31:0] mem_q [RAM_DEPTH];

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] scratch_q, scratch_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic              w_acc, w_wr, w_rd;
  logic              w_ram_hit, w_io_hit, w_unmapped;
  logic [1:0]        w_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [31:0]       w_io_rdata;
  logic              unused_addr_lsb;

  // An access in a reset cycle is dropped entirely.
  assign w_acc      = CS & RST;
  assign w_wr       = w_acc & WR;
  assign w_rd       = w_acc & ~WR;
  assign w_ram_hit  = (ADDR[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
  assign w_io_hit   = (ADDR[31:4] == IO_BASE[31:4]);
  assign w_unmapped = w_acc & ~w_ram_hit & ~w_io_hit;
  assign w_off      = ADDR[3:2];
  assign w_ram_idx  = ADDR[RAM_AW+1:2];
  assign unused_addr_lsb = ^ADDR[1:0];

  always_comb begin
    w_io_rdata = err_addr_q;
    case (w_off)
      OFF_CNT:  w_io_rdata = cnt_q;
      OFF_SCR:  w_io_rdata = scratch_q;
      OFF_STAT: w_io_rdata = {31'b0, err_q};
      default:  w_io_rdata = err_addr_q;
    endcase
  end

  always_comb begin
    // Counter clear beats the free-running increment.
    cnt_d = cnt_q + 32'd1;
    if (w_wr && !w_ram_hit && w_io_hit && (w_off == OFF_CNT))
      cnt_d = 32'd0;

    scratch_d = scratch_q;
    if (w_wr && !w_ram_hit && w_io_hit && (w_off == OFF_SCR))
      scratch_d = Data_BUS_WRITE;

    // New error set takes precedence over a coincident W1C clear.
    err_d = err_q;
    if (w_wr && !w_ram_hit && w_io_hit && (w_off == OFF_STAT) && Data_BUS_WRITE[0])
      err_d = 1'b0;
    if (w_unmapped)
      err_d = 1'b1;

    err_addr_d = w_unmapped ? ADDR : err_addr_q;

    rd_valid_d = w_rd;
    rd_data_d  = UNMAPPED_DATA;
    if (w_ram_hit)
      rd_data_d = mem_q[w_ram_idx];
    else if (w_io_hit)
      rd_data_d = w_io_rdata;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q      <= 32'd0;
      scratch_q  <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      scratch_q  <= scratch_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // RAM has no reset; a read in the cycle after a write sees the new word
  // because the write has already landed at the previous edge.
  always_ff @(posedge CLK) begin
    if (w_wr && w_ram_hit)
      mem_q[w_ram_idx] <= Data_BUS_WRITE;
  end

  assign Data_BUS_READ = rd_valid_q ? rd_data_q : 32'hz;
  assign ERR_IRQ       = err_q;

  a_no_x_on_access : assert property (@(posedge CLK) (RST && CS) |-> !$isunknown({ADDR, WR}));

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_bus_responder
//  Purpose  : Directed self-checking bench for data_bus_responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_responder;

  localparam logic [31:0] IO = 32'h0000_FF00;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] ADDR = 32'd0;
  logic [31:0] DW = 32'd0;
  logic        CS = 1'b0;
  logic        WR = 1'b0;
  wire  [31:0] Data_BUS_READ;
  wire         ERR_IRQ;

  int n_checks = 0;
  int n_errors = 0;

  data_bus_responder dut (
    .CLK            (CLK),
    .RST            (RST),
    .ADDR           (ADDR),
    .Data_BUS_WRITE (DW),
    .CS             (CS),
    .WR             (WR),
    .Data_BUS_READ  (Data_BUS_READ),
    .ERR_IRQ        (ERR_IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge and are held across the next
  // rising edge; the task returns at the following falling edge, where the
  // results of that rising edge are visible.
  task automatic cyc(input logic cs, input logic wr, input logic [31:0] a, input logic [31:0] d);
    CS = cs; WR = wr; ADDR = a; DW = d;
    @(negedge CLK);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic bus_rd(input logic [31:0] a);
    cyc(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_hiz(input string tag);
    check(tag, {31'b0, dut.rd_valid_q}, 32'd0);
  endtask

  logic [31:0] c1, c2;

  initial begin
    // Reset
    RST = 1'b0;
    repeat (4) idle();
    check_hiz("rst_hiz");
    check("rst_irq", {31'b0, ERR_IRQ}, 32'd0);
    RST = 1'b1;
    bus_rd(IO + 32'h8);
    check("rst_status", Data_BUS_READ, 32'd0);

    // RAM write then read-after-write
    bus_wr(32'h0000_0010, 32'h1234_5678);
    check_hiz("wr_hiz");
    bus_rd(32'h0000_0010);
    check("raw_0x10", Data_BUS_READ, 32'h1234_5678);
    bus_rd(32'h0000_0013);
    check("rd_0x13", Data_BUS_READ, 32'h1234_5678);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) bus_wr(32'(i * 4), 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      bus_rd(32'(i * 4));
      check($sformatf("b2b_%0d", i), Data_BUS_READ, 32'hA0 + 32'(i));
    end
    idle();
    check_hiz("b2b_hiz");

    // Counter: 5-cycle spacing
    bus_rd(IO);
    c1 = Data_BUS_READ;
    repeat (4) idle();
    bus_rd(IO);
    c2 = Data_BUS_READ;
    check("cnt_diff", c2 - c1, 32'd5);

    // Counter: clear at N, read at N+3
    bus_wr(IO, 32'h1234);
    idle();
    idle();
    bus_rd(IO);
    check("cnt_clr", Data_BUS_READ, 32'd2);

    // Counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    bus_rd(IO);
    check("cnt_max", Data_BUS_READ, 32'hFFFF_FFFF);
    bus_rd(IO);
    check("cnt_wrap", Data_BUS_READ, 32'd0);

    // Unmapped read
    bus_rd(32'h0001_0000);
    check("unmap_data", Data_BUS_READ, 32'hDEAD_BEEF);
    check("unmap_irq", {31'b0, ERR_IRQ}, 32'd1);
    bus_rd(IO + 32'hC);
    check("err_addr", Data_BUS_READ, 32'h0001_0000);
    bus_rd(IO + 32'h8);
    check("status_err", Data_BUS_READ, 32'd1);

    // Unmapped write loads ERR_ADDR
    bus_wr(32'h0002_0004, 32'h5555_5555);
    bus_rd(IO + 32'hC);
    check("err_addr_wr", Data_BUS_READ, 32'h0002_0004);

    // W1C on STATUS
    bus_wr(IO + 32'h8, 32'd0);
    check("w0_keeps", {31'b0, ERR_IRQ}, 32'd1);
    bus_wr(IO + 32'h8, 32'd1);
    check("w1c_irq", {31'b0, ERR_IRQ}, 32'd0);

    // Scratch and ignored writes
    bus_wr(IO + 32'h4, 32'hCAFE_0001);
    bus_rd(IO + 32'h4);
    check("scratch", Data_BUS_READ, 32'hCAFE_0001);
    bus_wr(IO + 32'h8, 32'hFFFF_FFFE);
    bus_rd(IO + 32'h8);
    check("status_hi", Data_BUS_READ, 32'd0);
    bus_wr(IO + 32'hC, 32'd0);
    bus_rd(IO + 32'hC);
    check("err_addr_ro", Data_BUS_READ, 32'h0002_0004);
    check("ro_no_err", {31'b0, ERR_IRQ}, 32'd0);

    // Reset during a RAM write, with a read pending from the previous edge
    bus_wr(32'h0000_0020, 32'h1111_1111);
    bus_rd(32'h0000_0010);
    check("pre_rst_rd", Data_BUS_READ, 32'h1234_5678);
    RST = 1'b0;
    bus_wr(32'h0000_0020, 32'h5555_5555);
    check_hiz("rst_drop_hiz");
    RST = 1'b1;
    bus_rd(IO + 32'h4);
    check("scratch_rst", Data_BUS_READ, 32'd0);
    bus_rd(32'h0000_0020);
    check("ram_wr_drop", Data_BUS_READ, 32'h1111_1111);
    check("rst_no_err", {31'b0, ERR_IRQ}, 32'd0);
    idle();
    check_hiz("end_hiz");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Slave end of the CPU data bus: answers the ADDR / Data_BUS_WRITE / Data_BUS_READ / CS / WR accesses the CPU issues.
- Contains a word-addressed data RAM and a small memory-mapped register bank: cycle counter, scratch register, error status, and error address.
- Sits beside the CPU at top level. Replaces the high-Z stub on Data_BUS_READ in the CPU bench.

Parameters:
- RAM_AW, 10, RAM word-address width; RAM depth is 2**RAM_AW words.
- RAM_BASE, 32'h0000_0000, byte base address of the RAM region (aligned to RAM size).
- IO_BASE, 32'h0000_FF00, byte base address of the 16-byte register block.
- UNMAPPED_DATA, 32'hDEAD_BEEF, value returned on a read that decodes to nothing.

Ports:
- CLK  in  1  single system clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-low; sampled on the CLK rising edge.
- ADDR  in  32  byte address from the CPU; ADDR[1:0] is ignored (word accesses only).
- Data_BUS_WRITE  in  32  write data from the CPU.
- CS  in  1  access strobe; high for exactly the cycle(s) an access is requested.
- WR  in  1  qualifies CS: 1 = write, 0 = read.
- Data_BUS_READ  out  32  registered read data; 32'hz when not driving.
- ERR_IRQ  out  1  level equal to STATUS.ERR.

Behaviour:
- Decode, per cycle with CS=1:
  - RAM hit: ADDR[31:RAM_AW+2] equals RAM_BASE[31:RAM_AW+2].
  - IO hit: ADDR[31:4] equals IO_BASE[31:4].
  - Otherwise unmapped.
- IO map (offset = ADDR[3:2]):
  - 0 = CYCLE_CNT: read returns count; any write clears it.
  - 1 = SCRATCH: read/write.
  - 2 = STATUS: bit0 ERR, write-1-to-clear; bits 31:1 read 0.
  - 3 = ERR_ADDR: read-only; holds the full ADDR of the last unmapped access.
- Write (CS=1, WR=1):
  - Committed on the same rising edge. No wait states.
  - Data_BUS_READ goes z on the following cycle.
- Read (CS=1, WR=0):
  - Data is sampled at edge N and driven on Data_BUS_READ from after edge N until edge N+1. Latency is one cycle.
  - Back-to-back reads update every cycle.
  - The first cycle after CS=0 or after a write sets Data_BUS_READ to z.
- Read-after-write to the same RAM word in consecutive cycles returns the new data; the write completes before the read samples.
- CYCLE_CNT:
  - Free-running, increments every cycle and wraps 32'hFFFF_FFFF -> 0.
  - A write and an increment in the same cycle: the clear wins; value 0 on the next cycle, then 1, 2, ...
  - A read returns the value held before the sampling edge.
- Unmapped access (read or write):
  - Sets ERR and loads ERR_ADDR.
  - A read returns UNMAPPED_DATA.
  - A write is discarded.
- ERR precedence: if a W1C write to STATUS coincides with a new error set, set wins. This cannot occur in a single access; it is stated for future multi-source use.
- Writes to ERR_ADDR and to STATUS bits 31:1 are ignored without error.
- Reset (RST=0 at an edge):
  - Data_BUS_READ = z, CYCLE_CNT = 0, SCRATCH = 0, STATUS = 0, ERR_ADDR = 0, ERR_IRQ = 0.
  - RAM contents are not reset (X in simulation; optional $readmemh init file).
- Reset mid-operation: an access presented in a cycle with RST=0 is dropped (no RAM write, no error). A read pending from the previous edge is replaced by z.
- CS asserted with ADDR or WR = X: no state change is required, but simulation shall flag an assertion.

Test Plan:
- Reset: hold RST=0 for 4 cycles, release -> Data_BUS_READ=z, ERR_IRQ=0; read IO_BASE+8 returns 0.
- RAM write/read: write 32'h1234_5678 to 0x0000_0010, then read 0x0000_0010 in the next cycle -> 32'h1234_5678 one cycle later; read 0x0000_0013 -> same word.
- Back-to-back reads: fill words 0..3 with 0xA0..0xA3, then read 0,4,8,C on consecutive cycles -> 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then z.
- Counter:
  - Read CYCLE_CNT twice, 5 cycles apart -> difference 5.
  - Write CYCLE_CNT at edge N, read it at edge N+3 -> 2.
  - Force the count to 32'hFFFF_FFFF via hierarchical deposit -> next value 0.
- Unmapped access: read 0x0001_0000 -> 32'hDEAD_BEEF, ERR_IRQ=1, ERR_ADDR reads 32'h0001_0000.
- Error clear and reset: write 1 to STATUS -> ERR_IRQ=0. Write SCRATCH=32'hCAFE_0001, assert RST=0 during a RAM write to 0x20 -> SCRATCH reads 0 and the 0x20 write is dropped.
